// File: rtl/spm_ctrl.sv
// spm_ctrl: sequencer around an external serial-parallel multiplier (SPM).
// Captures a signed operand pair on start, clears the SPM, holds the
// multiplicand on the parallel input, streams the sign-extended multiplier
// LSB-first, and deserialises the 2*WIDTH-bit serial product.
module spm_ctrl #(
   parameter int WIDTH   = 8,
   parameter int SPM_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     mcand,
   input  logic [WIDTH-1:0]     mplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [WIDTH-1:0]     spm_x,
   output logic                 spm_y,
   output logic                 spm_clr,
   input  logic                 spm_p
);

   // Last SHIFT count: 2*WIDTH product bits plus the SPM pipeline delay.
   localparam int LAST  = 2*WIDTH + SPM_LAT - 1;
   localparam int CNT_W = (LAST > 0) ? $clog2(LAST + 1) : 1;

   localparam logic [31:0] LAST_U  = 32'(LAST);
   localparam logic [31:0] W_U     = 32'(WIDTH);
   localparam logic [31:0] WM1_U   = 32'(WIDTH - 1);
   localparam logic [31:0] W2_U    = 32'(2*WIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_SHIFT = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     xreg_q, xreg_d;
   logic [WIDTH-1:0]     yreg_q, yreg_d;
   logic [2*WIDTH-1:0]   cap_q, cap_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 done_q, done_d;

   logic [31:0]          cnt_ext;
   logic                 cap_en;

   assign cnt_ext = 32'(cnt_q);

   // Product bits start arriving SPM_LAT cycles into SHIFT.
   generate
      if (SPM_LAT == 0) begin : g_cap_always
         assign cap_en = 1'b1;
      end else begin : g_cap_delayed
         assign cap_en = (cnt_ext >= 32'(SPM_LAT));
      end
   endgenerate

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         xreg_q    <= '0;
         yreg_q    <= '0;
         cap_q     <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         xreg_q    <= xreg_d;
         yreg_q    <= yreg_d;
         cap_q     <= cap_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   // Next-state logic and SPM-facing outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      xreg_d    = xreg_q;
      yreg_d    = yreg_q;
      cap_d     = cap_q;
      product_d = product_q;
      done_d    = 1'b0;
      busy      = 1'b0;
      spm_clr   = 1'b0;
      spm_y     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               xreg_d  = mcand;
               yreg_d  = mplier;
               state_d = S_CLEAR;
            end
         end

         S_CLEAR: begin
            busy    = 1'b1;
            spm_clr = 1'b1;
            cnt_d   = '0;
            cap_d   = '0;
            state_d = S_SHIFT;
         end

         S_SHIFT: begin
            busy = 1'b1;
            // Multiplier bits LSB-first, then its sign for the upper half.
            if (cnt_ext < W_U) begin
               spm_y = yreg_q[0];
            end else if (cnt_ext < W2_U) begin
               spm_y = yreg_q[WIDTH-1];
            end else begin
               spm_y = 1'b0;
            end

            // Arithmetic shift keeps the sign bit in place for the extension.
            if (cnt_ext < WM1_U) begin
               yreg_d = {yreg_q[WIDTH-1], yreg_q[WIDTH-1:1]};
            end

            // Serial product enters at the top; first bit ends up at bit 0.
            if (cap_en) begin
               cap_d = {spm_p, cap_q[2*WIDTH-1:1]};
            end

            if (cnt_ext == LAST_U) begin
               state_d   = S_IDLE;
               product_d = cap_d;
               done_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign spm_x   = xreg_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_spm_ctrl.sv
// tb_spm_ctrl: three controller instances (SPM_LAT = 0, 1, 2), each paired
// with a behavioural SPM that produces product bit k of x * Y once the k-th
// serial y bit has been presented, delayed by SPM_LAT cycles.
module tb_spm_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  start_v = '0;
   logic [7:0]  mcand_v  [3];
   logic [7:0]  mplier_v [3];
   logic [2:0]  busy_v;
   logic [2:0]  done_v;
   logic [15:0] product_v [3];
   logic [7:0]  spm_x_v [3];
   logic [2:0]  spm_y_v;
   logic [2:0]  spm_clr_v;
   logic [2:0]  spm_p_v;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_lane
         logic [15:0] acc;
         logic [4:0]  kk;
         logic [3:0]  pipe;
         logic [15:0] xs;
         logic [15:0] sum;
         logic        p_now;

         spm_ctrl #(.WIDTH(8), .SPM_LAT(gi)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start_v[gi]),
            .mcand   (mcand_v[gi]),
            .mplier  (mplier_v[gi]),
            .busy    (busy_v[gi]),
            .done    (done_v[gi]),
            .product (product_v[gi]),
            .spm_x   (spm_x_v[gi]),
            .spm_y   (spm_y_v[gi]),
            .spm_clr (spm_clr_v[gi]),
            .spm_p   (spm_p_v[gi])
         );

         // Behavioural SPM: running sum of x * y_k * 2^k, emitting bit k.
         assign xs    = {{8{spm_x_v[gi][7]}}, spm_x_v[gi]};
         assign sum   = acc + (spm_y_v[gi] ? (xs << kk) : 16'd0);
         assign p_now = sum[kk[3:0]];

         always @(posedge clk) begin
            if (spm_clr_v[gi]) begin
               acc  <= '0;
               kk   <= '0;
               pipe <= '0;
            end else begin
               acc  <= sum;
               if (kk != 5'd31) kk <= kk + 5'd1;
               pipe <= {pipe[2:0], p_now};
            end
         end

         if (gi == 0) begin : g_lat0
            assign spm_p_v[gi] = p_now;
         end else begin : g_latn
            assign spm_p_v[gi] = pipe[gi-1];
         end
      end
   endgenerate

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One operation on lane idx; checks clear, latency, busy length, product.
   task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] exp_p;
      int dc;
      int bc;
      int c;
      exp_p = $signed(a) * $signed(b);
      mcand_v[idx]  = a;
      mplier_v[idx] = b;
      start_v[idx]  = 1'b1;
      tick();
      start_v[idx]  = 1'b0;
      mcand_v[idx]  = 8'($urandom);
      mplier_v[idx] = 8'($urandom);
      check("clr_cycle1", 32'(spm_clr_v[idx]), 32'd1);
      dc = -1;
      bc = 0;
      c  = 1;
      while (dc < 0 && c < 40) begin
         if (busy_v[idx]) bc++;
         if (done_v[idx]) dc = c;
         else begin
            tick();
            c++;
         end
      end
      check("done_cycle", 32'(dc), 32'(18 + idx));
      check("busy_len", 32'(bc), 32'(17 + idx));
      check("product", 32'(product_v[idx]), 32'(exp_p));
      $display("op lane=%0d lat=%0d %0d*%0d -> 0x%04h (exp 0x%04h) done@%0d",
               idx, idx, $signed(a), $signed(b), product_v[idx], exp_p, dc);
      tick();
      check("done_pulse", 32'(done_v[idx]), 32'd0);
   endtask

   initial begin
      int seen;
      for (int i = 0; i < 3; i++) begin
         mcand_v[i]  = '0;
         mplier_v[i] = '0;
      end
      repeat (3) tick();
      rst = 1'b0;

      // Reset state and quiet idle period.
      for (int i = 0; i < 3; i++) begin
         check("rst_busy", 32'(busy_v[i]), 32'd0);
         check("rst_product", 32'(product_v[i]), 32'd0);
         check("rst_spm_x", 32'(spm_x_v[i]), 32'd0);
      end
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         if (spm_clr_v != 3'b000 || done_v != 3'b000 || spm_y_v != 3'b000) seen++;
         tick();
      end
      check("idle_quiet", 32'(seen), 32'd0);

      // Directed cases on the default-latency lane.
      run_op(1, 8'd3, 8'd5);
      run_op(1, 8'hFD, 8'd5);
      run_op(1, 8'd127, 8'h80);
      run_op(1, 8'h80, 8'h80);
      run_op(1, 8'd0, 8'hFF);

      // Start while busy is ignored; back-to-back start in the done cycle.
      mcand_v[1] = 8'd7; mplier_v[1] = 8'd9; start_v[1] = 1'b1;
      tick();
      start_v[1] = 1'b0;
      repeat (5) tick();
      mcand_v[1] = 8'd2; mplier_v[1] = 8'd2; start_v[1] = 1'b1;
      tick();
      start_v[1] = 1'b0;
      check("ignored_x", 32'(spm_x_v[1]), 32'd7);
      repeat (12) tick();
      check("b2b_done1", 32'(done_v[1]), 32'd1);
      check("b2b_prod1", 32'(product_v[1]), 32'h003F);
      $display("op lane=1 7*9 with ignored start -> 0x%04h", product_v[1]);
      mcand_v[1] = 8'd2; mplier_v[1] = 8'd2; start_v[1] = 1'b1;
      tick();
      start_v[1] = 1'b0;
      check("b2b_clr", 32'(spm_clr_v[1]), 32'd1);
      check("b2b_done_low", 32'(done_v[1]), 32'd0);
      check("b2b_hold", 32'(product_v[1]), 32'h003F);
      repeat (18) tick();
      check("b2b_done2", 32'(done_v[1]), 32'd1);
      check("b2b_prod2", 32'(product_v[1]), 32'h0004);
      $display("op lane=1 2*2 back-to-back -> 0x%04h", product_v[1]);
      tick();

      // Reset mid-operation aborts with no done.
      mcand_v[1] = 8'd10; mplier_v[1] = 8'd10; start_v[1] = 1'b1;
      tick();
      start_v[1] = 1'b0;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", 32'(busy_v[1]), 32'd0);
      check("abort_product", 32'(product_v[1]), 32'd0);
      seen = 0;
      for (int c = 0; c < 25; c++) begin
         if (done_v[1] || busy_v[1]) seen++;
         tick();
      end
      check("abort_no_done", 32'(seen), 32'd0);
      $display("op lane=1 10*10 aborted by reset");
      run_op(1, 8'd10, 8'd10);

      // Random signed pairs on every latency build.
      for (int n = 0; n < 100; n++) begin
         for (int idx = 0; idx < 3; idx++) begin
            run_op(idx, 8'($urandom), 8'($urandom));
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/spm_ctrl.md
Name: spm_ctrl

Overview:
- Sequencer that sits directly upstream and downstream of the 8-bit serial-parallel multiplier (SPM).
- Accepts a signed multiplicand/multiplier pair on a start pulse and clears the SPM.
- Holds the multiplicand on the SPM parallel input and streams the multiplier LSB-first, sign-extended, on the SPM serial input.
- Deserialises the SPM serial product into a 16-bit signed result, then signals completion with a one-cycle done pulse.

Parameters:
- WIDTH, 8: operand width; must match the SPM parallel width; product is 2*WIDTH bits.
- SPM_LAT, 1: cycles from a y bit presented on spm_y to the corresponding product bit on spm_p; range 0..3.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only while idle
- mcand  input  WIDTH  signed multiplicand, sampled with start
- mplier  input  WIDTH  signed multiplier, sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when product is updated
- product  output  2*WIDTH  signed result; holds until the next completion
- spm_x  output  WIDTH  to SPM x (parallel multiplicand)
- spm_y  output  1  to SPM y (serial multiplier bit)
- spm_clr  output  1  to SPM clr (clears SPM internal state)
- spm_p  input  1  from SPM p (serial product bit)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: state=IDLE; busy=0, done=0, product=0, spm_x=0, spm_y=0, spm_clr=0; counter=0; operand and capture registers=0.
- Reset mid-operation aborts the operation. No done is produced. product returns to 0.
- FSM has three states: IDLE, CLEAR, SHIFT.
- IDLE
  - On start=1: latch mcand into xreg and mplier into yreg; go to CLEAR.
  - start=0: stay in IDLE.
- CLEAR (exactly 1 cycle)
  - spm_clr=1, busy=1; counter<=0; go to SHIFT.
- SHIFT (exactly 2*WIDTH+SPM_LAT cycles)
  - busy=1, spm_clr=0.
  - spm_y = yreg[0] when counter < WIDTH, yreg[WIDTH-1] (sign extension) when WIDTH <= counter < 2*WIDTH, 0 afterwards.
  - yreg shifts right once per cycle while counter < WIDTH-1; the MSB is retained.
  - When counter >= SPM_LAT: capture register shifts right with spm_p entering bit 2*WIDTH-1. After 2*WIDTH captures, bit 0 holds the first captured bit (the LSB).
  - On the last cycle (counter = 2*WIDTH+SPM_LAT-1): next state IDLE, product<=final capture value (including this cycle's bit), done<=1.
  - Otherwise counter increments.
- spm_x = xreg throughout CLEAR and SHIFT and in IDLE; xreg changes only on an accepted start.
- spm_y = 0 outside SHIFT.
- Latency: if start is sampled high in cycle 0, done=1 in cycle 2*WIDTH+SPM_LAT+2 (19 for the defaults). busy is high in cycles 1 .. 2*WIDTH+SPM_LAT+1.
- done is high for exactly one cycle and coincides with the first IDLE cycle. start in that same cycle is accepted (back-to-back operation); product stays valid.
- start while busy=1 is ignored. No queuing occurs, and operand registers stay unchanged.
- mcand and mplier may change freely after the start cycle.
- Arithmetic is two's complement; the result is exact for all operand pairs, including -128*-128 = +16384.
- product changes only in the cycle done is asserted.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, product=0x0000, spm_clr never asserted.
- mcand=3, mplier=5, start -> spm_clr=1 in cycle 1; done in cycle 19 (SPM_LAT=1); product=0x000F.
- Signed cases, one each -> product:
  - -3 * 5 -> 0xFFF1
  - 127 * -128 -> 0xC080
  - -128 * -128 -> 0x4000
  - 0 * -1 -> 0x0000
- Start 7*9; pulse start with 2*2 at cycle 6 -> ignored; product=0x003F at done. Re-issue 2*2 in the done cycle -> second done 19 cycles later, product=0x0004.
- Start 10*10; assert rst at cycle 8 -> next cycle busy=0, product=0, no done. A new 10*10 then yields 0x0064.
- SPM_LAT=0 and SPM_LAT=2 builds with a behavioural SPM model; 100 random signed pairs -> product matches reference multiply; done at cycle 18+SPM_LAT.
